// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types, widths and helpers for the L2 port arbiter
package l2_arb_pkg;

    localparam int S_LINE = 256;
    localparam int S_ADDR = 32;
    localparam int S_OFF  = 5;

    // Clears the byte-offset bits so every L2 access is line aligned
    localparam logic [S_ADDR-1:0] LINE_MASK = {{(S_ADDR-S_OFF){1'b1}}, {S_OFF{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    function automatic logic [S_ADDR-1:0] line_align(input logic [S_ADDR-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// rtl/l2_arbiter_if.sv - bundle of L1 request/response and L2 port signals
interface l2_arbiter_if;
    import l2_arb_pkg::*;

    logic              icache_read;
    logic [S_ADDR-1:0] icache_address;
    logic [S_LINE-1:0] icache_rdata;
    logic              icache_resp;

    logic              dcache_read;
    logic              dcache_write;
    logic [S_ADDR-1:0] dcache_address;
    logic [S_LINE-1:0] dcache_wdata;
    logic [S_LINE-1:0] dcache_rdata;
    logic              dcache_resp;

    logic              l2_read;
    logic              l2_write;
    logic [S_ADDR-1:0] l2_address;
    logic [S_LINE-1:0] l2_wdata;
    logic [S_LINE-1:0] l2_rdata;
    logic              l2_resp;

    // Arbiter side
    modport slave (
        input  icache_read, icache_address,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  l2_rdata, l2_resp,
        output icache_rdata, icache_resp,
        output dcache_rdata, dcache_resp,
        output l2_read, l2_write, l2_address, l2_wdata
    );

    // Environment side: the L1 caches and l2_cache together
    modport master (
        output icache_read, icache_address,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        output l2_rdata, l2_resp,
        input  icache_rdata, icache_resp,
        input  dcache_rdata, dcache_resp,
        input  l2_read, l2_write, l2_address, l2_wdata
    );

endinterface

// File: rtl/l2_arbiter_pick.sv
// rtl/l2_arbiter_pick.sv - two-way round-robin requester pick
module l2_arbiter_pick
    import l2_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last_grant,
    output logic   valid,
    output grant_t grant
);

    // A lone requester wins outright; on a tie the one not served last wins
    always_comb begin
        valid = req_i | req_d;
        grant = GNT_I;
        if (req_i && req_d) begin
            grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (req_d) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - shares one L2 line port between the L1 I-cache and D-cache
module l2_arbiter
    import l2_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    l2_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [S_ADDR-1:0] addr_q, addr_d;
    logic [S_LINE-1:0] wdata_q, wdata_d;

    logic   pick_valid;
    grant_t pick_grant;

    l2_arbiter_pick u_pick (
        .req_i      (bus.icache_read),
        .req_d      (bus.dcache_read | bus.dcache_write),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    // State and capture registers; last_grant resets to I so D wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Grant only from IDLE; the captured command is held until l2_resp, then
    // DONE gives the served L1 a cycle to drop its level request
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        read_d       = read_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    last_grant_d = pick_grant;
                    if (pick_grant == GNT_D) begin
                        state_d = BUSY_D;
                        // A simultaneous read+write is illegal; the write wins
                        read_d  = bus.dcache_read & ~bus.dcache_write;
                        write_d = bus.dcache_write;
                        addr_d  = line_align(bus.dcache_address);
                        wdata_d = bus.dcache_wdata;
                    end else begin
                        state_d = BUSY_I;
                        read_d  = 1'b1;
                        write_d = 1'b0;
                        addr_d  = line_align(bus.icache_address);
                        wdata_d = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.l2_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    assign bus.l2_read      = read_q;
    assign bus.l2_write     = write_q;
    assign bus.l2_address   = addr_q;
    assign bus.l2_wdata     = wdata_q;

    // Responses only reach the granted requester; rdata is a plain fan-out
    assign bus.icache_resp  = (state_q == BUSY_I) & bus.l2_resp;
    assign bus.dcache_resp  = (state_q == BUSY_D) & bus.l2_resp;
    assign bus.icache_rdata = bus.l2_rdata;
    assign bus.dcache_rdata = bus.l2_rdata;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(bus.dcache_read && bus.dcache_write))
        else $warning("dcache_read and dcache_write both high, write taken");

    a_resp_in_busy: assert property (@(posedge clk) disable iff (!rst)
        bus.l2_resp |-> (state_q == BUSY_I || state_q == BUSY_D))
        else $warning("stray l2_resp outside a granted transaction ignored");

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - directed table and sequence bench for l2_arbiter
module tb_l2_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    l2_arbiter_if bus ();

    l2_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         ir;
        logic [31:0]  ia;
        logic         dr;
        logic         dw;
        logic [31:0]  da;
        logic [255:0] wd;
        logic         exp_d;
        logic         exp_rd;
        logic         exp_wr;
        logic [31:0]  exp_addr;
        int           delay;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic ir, input logic [31:0] ia, input logic dr,
                           input logic dw, input logic [31:0] da, input logic [255:0] wd);
        bus.icache_read    = ir;
        bus.icache_address = ia;
        bus.dcache_read    = dr;
        bus.dcache_write   = dw;
        bus.dcache_address = da;
        bus.dcache_wdata   = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        bus.l2_resp  = 1'b0;
        bus.l2_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Entered at a negedge in IDLE with requests already driven; returns at the
    // negedge of the following IDLE cycle. gcyc is the cycle count at the grant.
    task automatic run_txn(input string nm, input logic exp_d, input logic exp_rd,
                           input logic exp_wr, input logic [31:0] exp_addr,
                           input logic [255:0] exp_wdata, input int delay,
                           input bit drop, output int gcyc);
        int           held;
        logic [255:0] rd;
        held = 0;
        @(posedge clk);
        @(negedge clk);
        gcyc = cyc;
        check({nm, ".l2_read"},    bus.l2_read,    exp_rd);
        check({nm, ".l2_write"},   bus.l2_write,   exp_wr);
        check({nm, ".l2_address"}, bus.l2_address, exp_addr);
        if (exp_wr) check({nm, ".l2_wdata"}, bus.l2_wdata, exp_wdata);
        for (int k = 1; k < delay; k++) begin
            if (bus.l2_read === exp_rd && bus.l2_write === exp_wr && bus.l2_address === exp_addr)
                held++;
            check({nm, ".early_resp"}, {bus.icache_resp, bus.dcache_resp}, 2'b00);
            @(negedge clk);
        end
        if (bus.l2_read === exp_rd && bus.l2_write === exp_wr && bus.l2_address === exp_addr)
            held++;
        rd = {8{32'hA5C3_0000 + 32'(cyc)}};
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = rd;
        #1;
        check({nm, ".held_cycles"}, held, delay);
        if (exp_d) begin
            check({nm, ".dcache_resp"}, bus.dcache_resp, 1'b1);
            check({nm, ".icache_resp"}, bus.icache_resp, 1'b0);
            check({nm, ".dcache_rdata"}, bus.dcache_rdata, rd);
        end else begin
            check({nm, ".icache_resp"}, bus.icache_resp, 1'b1);
            check({nm, ".dcache_resp"}, bus.dcache_resp, 1'b0);
            check({nm, ".icache_rdata"}, bus.icache_rdata, rd);
        end
        @(negedge clk);
        bus.l2_resp = 1'b0;
        if (drop) begin
            if (exp_d) begin
                bus.dcache_read  = 1'b0;
                bus.dcache_write = 1'b0;
            end else begin
                bus.icache_read = 1'b0;
            end
        end
        #1;
        check({nm, ".done_cmd"},  {bus.l2_read, bus.l2_write}, 2'b00);
        check({nm, ".done_resp"}, {bus.icache_resp, bus.dcache_resp}, 2'b00);
        @(negedge clk);
    endtask

    initial begin
        int g_prev;
        int g_now;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        bus.l2_resp  = 1'b0;
        bus.l2_rdata = '0;

        // Table: sequential transactions; unserved requests stay high into the next row
        tbl[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, '0,
                   1'b0, 1'b1, 1'b0, 32'h0000_1220, 5};
        tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2007, '0,
                   1'b1, 1'b1, 1'b0, 32'h0000_2000, 2};
        tbl[2] = '{1'b1, 32'h3000_001F, 1'b0, 1'b1, 32'h4444_4444, {8{32'hDEAD_BEEF}},
                   1'b0, 1'b1, 1'b0, 32'h3000_0000, 3};
        tbl[3] = '{1'b0, 32'h3000_001F, 1'b0, 1'b1, 32'h4444_4444, {8{32'hDEAD_BEEF}},
                   1'b1, 1'b0, 1'b1, 32'h4444_4440, 1};
        tbl[4] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0020, '0,
                   1'b0, 1'b1, 1'b0, 32'hFFFF_FFE0, 2};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0020, '0,
                   1'b1, 1'b1, 1'b0, 32'h8000_0020, 4};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset.l2_cmd",     {bus.l2_read, bus.l2_write}, 2'b00);
        check("reset.l2_address", bus.l2_address, 32'h0);
        check("reset.l2_wdata",   bus.l2_wdata, '0);
        check("reset.resp",       {bus.icache_resp, bus.dcache_resp}, 2'b00);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            set_req(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].wd);
            run_txn($sformatf("tbl%0d", i), tbl[i].exp_d, tbl[i].exp_rd, tbl[i].exp_wr,
                    tbl[i].exp_addr, tbl[i].wd, tbl[i].delay, 1'b1, g_now);
        end

        // Simultaneous I read and D write after reset: D first, then I
        do_reset();
        set_req(1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0200, {8{32'h1357_9BDF}});
        run_txn("tie_d", 1'b1, 1'b0, 1'b1, 32'h0000_0200, {8{32'h1357_9BDF}}, 1, 1'b1, g_prev);
        run_txn("tie_i", 1'b0, 1'b1, 1'b0, 32'h0000_0100, '0, 1, 1'b1, g_now);
        check("tie.grant_gap_ge3", (g_now - g_prev) >= 3, 1'b1);

        // Both held continuously: strict alternation D,I,D,I,D,I
        do_reset();
        set_req(1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0600, '0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                run_txn($sformatf("rr%0d_d", i), 1'b1, 1'b1, 1'b0, 32'h0000_0600, '0, 2, 1'b0, g_now);
            else
                run_txn($sformatf("rr%0d_i", i), 1'b0, 1'b1, 1'b0, 32'h0000_0500, '0, 2, 1'b0, g_now);
            if (i > 0) check($sformatf("rr%0d.gap_ge3", i), (g_now - g_prev) >= 3, 1'b1);
            g_prev = g_now;
        end
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        repeat (2) @(negedge clk);

        // Address changes mid-transaction: captured copy stays on the L2 port
        set_req(1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0, '0);
        @(posedge clk);
        @(negedge clk);
        check("midchg.addr_grant", bus.l2_address, 32'h0000_0080);
        bus.icache_address = 32'h0000_0040;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midchg.addr_busy%0d", k), bus.l2_address, 32'h0000_0080);
        end
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = {8{32'h0BAD_F00D}};
        #1;
        check("midchg.addr_resp", bus.l2_address, 32'h0000_0080);
        check("midchg.icache_resp", bus.icache_resp, 1'b1);
        @(negedge clk);
        bus.l2_resp = 1'b0;
        bus.icache_read = 1'b0;
        @(negedge clk);

        // Stray l2_resp while IDLE is ignored
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = {8{32'hFFFF_0000}};
        #1;
        check("stray.resp", {bus.icache_resp, bus.dcache_resp}, 2'b00);
        @(negedge clk);
        bus.l2_resp = 1'b0;
        #1;
        check("stray.cmd", {bus.l2_read, bus.l2_write}, 2'b00);
        check("stray.resp_after", {bus.icache_resp, bus.dcache_resp}, 2'b00);
        set_req(1'b1, 32'h0000_1010, 1'b0, 1'b0, 32'h0, '0);
        run_txn("stray_next", 1'b0, 1'b1, 1'b0, 32'h0000_1000, '0, 1, 1'b1, g_now);

        // Reset during BUSY_D drops l2_write asynchronously
        set_req(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_7003, {8{32'h2468_ACE0}});
        @(posedge clk);
        @(negedge clk);
        check("rstbusy.write_before", bus.l2_write, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstbusy.write_async", bus.l2_write, 1'b0);
        check("rstbusy.read_async", bus.l2_read, 1'b0);
        check("rstbusy.addr_async", bus.l2_address, 32'h0);
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstbusy.idle_cmd", {bus.l2_read, bus.l2_write}, 2'b00);
        set_req(1'b1, 32'h0000_9008, 1'b0, 1'b0, 32'h0, '0);
        run_txn("rstbusy_next", 1'b0, 1'b1, 1'b0, 32'h0000_9000, '0, 2, 1'b1, g_now);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if the main sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
